mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/mem_arbiter_if.sv | 45 ++++
 rtl/mem_arbiter_pick.sv | 21 ++
 rtl/mem_arbiter.sv | 105 ++++++++++
 tb/tb_mem_arbiter.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM states and grant identifiers.
package mem_arb_types;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } arb_grant_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and shared-memory signal bundle for mem_arbiter.
// The slave modport is the arbiter; master is the surrounding caches and memory.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
);

  logic              icache_read;
  logic [ADDR_W-1:0] icache_address;
  logic [LINE_W-1:0] icache_rdata;
  logic              icache_resp;

  logic              dcache_read;
  logic              dcache_write;
  logic [ADDR_W-1:0] dcache_address;
  logic [LINE_W-1:0] dcache_wdata;
  logic [LINE_W-1:0] dcache_rdata;
  logic              dcache_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  icache_read, icache_address,
    input  dcache_read, dcache_write, dcache_address, dcache_wdata,
    input  pmem_rdata, pmem_resp,
    output icache_rdata, icache_resp,
    output dcache_rdata, dcache_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output icache_read, icache_address,
    output dcache_read, dcache_write, dcache_address, dcache_wdata,
    output pmem_rdata, pmem_resp,
    input  icache_rdata, icache_resp,
    input  dcache_rdata, dcache_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );

endinterface

// File: rtl/mem_arbiter_pick.sv
// Combinational winner selector: on contention grants the side not granted last,
// otherwise whichever side is requesting.
module mem_arb_pick
  import mem_arb_types::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  arb_grant_t last_grant,
  output arb_grant_t grant
);

  always_comb begin
    grant = GRANT_I;
    if (i_req && d_req) begin
      grant = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
    end else if (d_req) begin
      grant = GRANT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester cacheline arbiter in front of a single shared memory port.
// MEM_ARB_RR_EN: round-robin on contention; undefined, the data side always wins.
module mem_arbiter
  import mem_arb_types::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  arb_state_t        state;
  arb_grant_t        grant;
  arb_grant_t        last_grant;
  logic              rd_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              d_req;
  logic              done;

  assign d_req = bus.dcache_read | bus.dcache_write;
  assign done  = (state != IDLE) && bus.pmem_resp;

  mem_arb_pick u_pick (
    .i_req      (bus.icache_read),
    .d_req      (d_req),
    .last_grant (last_grant),
    .grant      (grant)
  );

`ifdef MEM_ARB_RR_EN
  // Pointer follows completed transactions, not grants, so an aborted one does not count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GRANT_I;
    end else if (done) begin
      last_grant <= (state == SERVE_D) ? GRANT_D : GRANT_I;
    end
  end
`else
  // Pinning the pointer to I makes the selector hand every contention to D.
  assign last_grant = GRANT_I;
`endif

  // Arbitration FSM; strobe, address and write line are frozen for the whole transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.icache_read || d_req) begin
            if (grant == GRANT_D) begin
              state   <= SERVE_D;
              addr_q  <= bus.dcache_address;
              wdata_q <= bus.dcache_wdata;
              wr_q    <= bus.dcache_write;
              rd_q    <= ~bus.dcache_write;
            end else begin
              state  <= SERVE_I;
              addr_q <= bus.icache_address;
              rd_q   <= 1'b1;
              wr_q   <= 1'b0;
            end
          end
        end
        SERVE_I, SERVE_D: begin
          if (bus.pmem_resp) begin
            state <= IDLE;
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          rd_q  <= 1'b0;
          wr_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pmem_read    = rd_q;
  assign bus.pmem_write   = wr_q;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;

  // Completion is passed through in the same cycle the memory answers.
  assign bus.icache_resp  = (state == SERVE_I) && bus.pmem_resp;
  assign bus.dcache_resp  = (state == SERVE_D) && bus.pmem_resp;
  assign bus.icache_rdata = bus.pmem_rdata;
  assign bus.dcache_rdata = bus.pmem_rdata;

  a_no_dual_kind : assert property (@(posedge clk) disable iff (rst)
    !(bus.dcache_read && bus.dcache_write))
    else $error("dcache_read and dcache_write asserted together");

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single-side transfers, contention, reset abort,
// and a requester dropping its request mid-transaction.
module tb_mem_arbiter;
  import mem_arb_types::*;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 256;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  logic [LINE_W-1:0] pat_a5;
  logic [LINE_W-1:0] line1;
  logic [LINE_W-1:0] line2;
  logic [LINE_W-1:0] line3;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    pat_a5 = {32{8'hA5}};
    line1  = {8{32'h1111_0001}};
    line2  = {8{32'h2222_0002}};
    line3  = {8{32'h3333_0003}};

    rst                = 1'b1;
    bus.icache_read    = 1'b0;
    bus.icache_address = '0;
    bus.dcache_read    = 1'b0;
    bus.dcache_write   = 1'b0;
    bus.dcache_address = '0;
    bus.dcache_wdata   = '0;
    bus.pmem_rdata     = '0;
    bus.pmem_resp      = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_pmem_read", 256'(bus.pmem_read), 256'(0));
    chk("rst_pmem_write", 256'(bus.pmem_write), 256'(0));
    chk("rst_pmem_address", 256'(bus.pmem_address), 256'(0));
    chk("rst_pmem_wdata", 256'(bus.pmem_wdata), 256'(0));
    chk("rst_icache_resp", 256'(bus.icache_resp), 256'(0));
    chk("rst_dcache_resp", 256'(bus.dcache_resp), 256'(0));
    rst = 1'b0;

    // I-side read, latency 3: strobe cycles 1-4, resp at cycle 4
    tick();
    bus.icache_read    = 1'b1;
    bus.icache_address = 32'h0000_0060;
    #1;
    chk("i_c0_read_low", 256'(bus.pmem_read), 256'(0));
    tick();
    chk("i_c1_read", 256'(bus.pmem_read), 256'(1));
    chk("i_c1_addr", 256'(bus.pmem_address), 256'(32'h60));
    chk("i_c1_write", 256'(bus.pmem_write), 256'(0));
    tick();
    chk("i_c2_read", 256'(bus.pmem_read), 256'(1));
    tick();
    chk("i_c3_read", 256'(bus.pmem_read), 256'(1));
    chk("i_c3_resp_low", 256'(bus.icache_resp), 256'(0));
    tick();
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = line1;
    #1;
    chk("i_c4_read", 256'(bus.pmem_read), 256'(1));
    chk("i_c4_resp", 256'(bus.icache_resp), 256'(1));
    chk("i_c4_rdata", bus.icache_rdata, line1);
    chk("i_c4_dresp", 256'(bus.dcache_resp), 256'(0));
    tick();
    bus.pmem_resp   = 1'b0;
    bus.icache_read = 1'b0;
    #1;
    chk("i_c5_read_low", 256'(bus.pmem_read), 256'(0));
    chk("i_c5_resp_low", 256'(bus.icache_resp), 256'(0));
    tick();
    chk("i_c6_idle", 256'(bus.pmem_read), 256'(0));

    // D-side write: held address/data despite requester changes, no read strobe
    bus.dcache_write   = 1'b1;
    bus.dcache_address = 32'h0000_1000;
    bus.dcache_wdata   = pat_a5;
    tick();
    chk("w_c1_write", 256'(bus.pmem_write), 256'(1));
    chk("w_c1_read", 256'(bus.pmem_read), 256'(0));
    chk("w_c1_addr", 256'(bus.pmem_address), 256'(32'h1000));
    chk("w_c1_wdata", bus.pmem_wdata, pat_a5);
    bus.dcache_address = 32'h0000_BEEF;
    bus.dcache_wdata   = '0;
    tick();
    chk("w_c2_addr_held", 256'(bus.pmem_address), 256'(32'h1000));
    chk("w_c2_wdata_held", bus.pmem_wdata, pat_a5);
    chk("w_c2_read", 256'(bus.pmem_read), 256'(0));
    bus.pmem_resp = 1'b1;
    #1;
    chk("w_c2_dresp", 256'(bus.dcache_resp), 256'(1));
    chk("w_c2_iresp", 256'(bus.icache_resp), 256'(0));
    tick();
    bus.pmem_resp    = 1'b0;
    bus.dcache_write = 1'b0;
    #1;
    chk("w_c3_write_low", 256'(bus.pmem_write), 256'(0));
    chk("w_c3_dresp_low", 256'(bus.dcache_resp), 256'(0));

    // Reset pulse returns the pointer to I before contention
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Contention, both held: first grant D, then I or D depending on the build
    bus.icache_read    = 1'b1;
    bus.icache_address = 32'h0000_0200;
    bus.dcache_read    = 1'b1;
    bus.dcache_address = 32'h0000_0300;
    tick();
    chk("c1_read", 256'(bus.pmem_read), 256'(1));
    chk("c1_addr_d", 256'(bus.pmem_address), 256'(32'h300));
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = line2;
    #1;
    chk("c1_dresp", 256'(bus.dcache_resp), 256'(1));
    chk("c1_drdata", bus.dcache_rdata, line2);
    chk("c1_iresp", 256'(bus.icache_resp), 256'(0));
    tick();
    bus.pmem_resp = 1'b0;
    #1;
    chk("c_gap_idle", 256'(bus.pmem_read), 256'(0));
    tick();
    chk("c2_read", 256'(bus.pmem_read), 256'(1));
`ifdef MEM_ARB_RR_EN
    chk("c2_addr", 256'(bus.pmem_address), 256'(32'h200));
`else
    chk("c2_addr", 256'(bus.pmem_address), 256'(32'h300));
`endif
    bus.pmem_resp = 1'b1;
    #1;
`ifdef MEM_ARB_RR_EN
    chk("c2_iresp", 256'(bus.icache_resp), 256'(1));
`else
    chk("c2_dresp", 256'(bus.dcache_resp), 256'(1));
`endif
    tick();
    bus.pmem_resp = 1'b0;
    tick();
    chk("c3_addr_d", 256'(bus.pmem_address), 256'(32'h300));
    bus.pmem_resp = 1'b1;
    #1;
    chk("c3_dresp", 256'(bus.dcache_resp), 256'(1));
    tick();
    bus.pmem_resp = 1'b0;
    bus.dcache_read = 1'b0;
    tick();
    chk("c4_addr_i", 256'(bus.pmem_address), 256'(32'h200));
    bus.pmem_resp = 1'b1;
    #1;
    chk("c4_iresp", 256'(bus.icache_resp), 256'(1));
    tick();
    bus.pmem_resp   = 1'b0;
    bus.icache_read = 1'b0;
    tick();
    chk("c_done_idle", 256'(bus.pmem_read), 256'(0));

    // Reset two cycles into a D read: strobe drops at once, late resp ignored
    bus.dcache_read    = 1'b1;
    bus.dcache_address = 32'h0000_0400;
    tick();
    chk("r_c1_read", 256'(bus.pmem_read), 256'(1));
    tick();
    rst             = 1'b1;
    bus.dcache_read = 1'b0;
    #1;
    chk("r_async_read", 256'(bus.pmem_read), 256'(0));
    chk("r_async_addr", 256'(bus.pmem_address), 256'(0));
    chk("r_async_dresp", 256'(bus.dcache_resp), 256'(0));
    tick();
    rst           = 1'b0;
    bus.pmem_resp = 1'b1;
    #1;
    chk("r_late_dresp", 256'(bus.dcache_resp), 256'(0));
    chk("r_late_iresp", 256'(bus.icache_resp), 256'(0));
    tick();
    bus.pmem_resp = 1'b0;
    #1;
    chk("r_stay_idle", 256'(bus.pmem_read), 256'(0));

    // I request dropped after grant still completes exactly once
    bus.icache_read    = 1'b1;
    bus.icache_address = 32'h0000_0080;
    tick();
    chk("d_c1_read", 256'(bus.pmem_read), 256'(1));
    bus.icache_read = 1'b0;
    tick();
    chk("d_c2_read", 256'(bus.pmem_read), 256'(1));
    chk("d_c2_addr", 256'(bus.pmem_address), 256'(32'h80));
    tick();
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = line3;
    #1;
    chk("d_c3_iresp", 256'(bus.icache_resp), 256'(1));
    chk("d_c3_rdata", bus.icache_rdata, line3);
    tick();
    bus.pmem_resp = 1'b0;
    #1;
    chk("d_c4_read_low", 256'(bus.pmem_read), 256'(0));
    chk("d_c4_iresp_low", 256'(bus.icache_resp), 256'(0));
    tick();
    chk("d_c5_no_reissue", 256'(bus.pmem_read), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
